// File: rtl/control_fsm_pkg.sv
// Shared encodings for the RV64I multicycle core: FSM states, opcodes, ALU-op classes
// and datapath select codes, reused by the control FSM, datapath and ALU decoder.
package control_fsm_pkg;

   typedef enum logic [4:0] {
      S_IDLE     = 5'd0,
      S_FETCH    = 5'd1,
      S_DECODE   = 5'd2,
      S_MEMADDR  = 5'd3,
      S_MEMREAD  = 5'd4,
      S_MEMWB    = 5'd5,
      S_MEMWRITE = 5'd6,
      S_EXEC_R   = 5'd7,
      S_EXEC_I   = 5'd8,
      S_EXEC_RW  = 5'd9,
      S_EXEC_IW  = 5'd10,
      S_ALUWB    = 5'd11,
      S_BRANCH   = 5'd12,
      S_JAL      = 5'd13,
      S_JALR     = 5'd14,
      S_JALR_WB  = 5'd15,
      S_LUI      = 5'd16,
      S_AUIPC    = 5'd17
   } t_state;

   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_OP        = 7'b0110011;
   localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP_32     = 7'b0111011;
   localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_LUI       = 7'b0110111;
   localparam logic [6:0] OP_AUIPC     = 7'b0010111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_IR  = 3'b010;
   localparam logic [2:0] ALU_IRW = 3'b011;

   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
   localparam logic [1:0] SRC_A_RS1    = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;
   localparam logic [1:0] RES_IMM    = 2'b11;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write_en;
      logic       ir_write_en;
      logic       pc_update;
      logic       branch;
      logic       reg_write_en;
      logic [2:0] alu_op;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       illegal_instr;
   } ctrl_t;

   // Control word with only the ALU operand selects and op set; everything else idle.
   function automatic ctrl_t alu_ctrl(input logic [1:0] src_a, input logic [1:0] src_b,
                                      input logic [2:0] op);
      ctrl_t c;
      c           = '0;
      c.alu_src_a = src_a;
      c.alu_src_b = src_b;
      c.alu_op    = op;
      return c;
   endfunction

   // func3 010/011 have no branch meaning in RV64I.
   function automatic logic is_illegal_branch(input logic [2:0] func3);
      return (func3 == 3'b010) || (func3 == 3'b011);
   endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the datapath/memory side (slave).
interface control_fsm_if;
   logic [6:0] i_op;
   logic [2:0] i_func3;
   logic       i_mem_done;
   logic       o_mem_req;
   logic       o_mem_write_en;
   logic       o_ir_write_en;
   logic       o_pc_update;
   logic       o_branch;
   logic       o_reg_write_en;
   logic [2:0] o_alu_op;
   logic [1:0] o_alu_src_a;
   logic [1:0] o_alu_src_b;
   logic [1:0] o_result_src;
   logic       o_illegal_instr;

   modport master (
      input  i_op, i_func3, i_mem_done,
      output o_mem_req, o_mem_write_en, o_ir_write_en, o_pc_update, o_branch,
             o_reg_write_en, o_alu_op, o_alu_src_a, o_alu_src_b, o_result_src,
             o_illegal_instr
   );

   modport slave (
      output i_op, i_func3, i_mem_done,
      input  o_mem_req, o_mem_write_en, o_ir_write_en, o_pc_update, o_branch,
             o_reg_write_en, o_alu_op, o_alu_src_a, o_alu_src_b, o_result_src,
             o_illegal_instr
   );
endinterface

// File: rtl/control_fsm_instr_class_decoder.sv
// Combinational opcode/func3 classifier: picks the state that follows DECODE and flags
// unsupported encodings (which send the FSM back to FETCH).
module instr_class_decoder
   import control_fsm_pkg::*;
(
   input  logic [6:0] op,
   input  logic [2:0] func3,
   output t_state     next_state,
   output logic       illegal
);

   // NOTE: every output gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      next_state = S_FETCH;
      illegal    = 1'b0;
      case (op)
         OP_LOAD, OP_STORE: next_state = S_MEMADDR;
         OP_OP:             next_state = S_EXEC_R;
         OP_OP_IMM:         next_state = S_EXEC_I;
         OP_OP_32:          next_state = S_EXEC_RW;
         OP_OP_IMM_32:      next_state = S_EXEC_IW;
         OP_JAL:            next_state = S_JAL;
         OP_JALR:           next_state = S_JALR;
         OP_LUI:            next_state = S_LUI;
         OP_AUIPC:          next_state = S_AUIPC;
         OP_BRANCH: begin
            if (is_illegal_branch(func3)) illegal    = 1'b1;
            else                          next_state = S_BRANCH;
         end
         default:           illegal    = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Main multicycle control FSM of the RV64I core: sequences fetch/decode/execute/memory/
// writeback over the shared single-ALU datapath and handshakes with the memory interface.
module control_fsm
   import control_fsm_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_arstn,
   control_fsm_if.master bus
);

   t_state state_q;
   t_state state_d;
   t_state dec_next;
   logic   dec_illegal;
   ctrl_t  ctrl;

   instr_class_decoder u_decoder (
      .op         (bus.i_op),
      .func3      (bus.i_func3),
      .next_state (dec_next),
      .illegal    (dec_illegal)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge value, independent of process evaluation order.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ctrl    = '0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;

         S_FETCH: begin
            ctrl            = alu_ctrl(SRC_A_PC, SRC_B_FOUR, ALU_ADD);
            ctrl.mem_req    = 1'b1;
            ctrl.result_src = RES_ALU;
            // IR/PC capture only in the cycle the fetched word is actually present.
            if (bus.i_mem_done) begin
               ctrl.ir_write_en = 1'b1;
               ctrl.pc_update   = 1'b1;
               state_d          = S_DECODE;
            end
         end

         S_DECODE: begin
            ctrl               = alu_ctrl(SRC_A_OLD_PC, SRC_B_IMM, ALU_ADD);
            ctrl.illegal_instr = dec_illegal;
            state_d            = dec_next;
         end

         S_MEMADDR: begin
            ctrl    = alu_ctrl(SRC_A_RS1, SRC_B_IMM, ALU_ADD);
            state_d = (bus.i_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end

         S_MEMREAD: begin
            ctrl.mem_req    = 1'b1;
            ctrl.result_src = RES_ALUOUT;
            if (bus.i_mem_done) state_d = S_MEMWB;
         end

         S_MEMWB: begin
            ctrl.result_src   = RES_MEM;
            ctrl.reg_write_en = 1'b1;
            state_d           = S_FETCH;
         end

         S_MEMWRITE: begin
            ctrl.mem_req      = 1'b1;
            ctrl.mem_write_en = 1'b1;
            ctrl.result_src   = RES_ALUOUT;
            if (bus.i_mem_done) state_d = S_FETCH;
         end

         S_EXEC_R: begin
            ctrl    = alu_ctrl(SRC_A_RS1, SRC_B_RS2, ALU_IR);
            state_d = S_ALUWB;
         end

         S_EXEC_I: begin
            ctrl    = alu_ctrl(SRC_A_RS1, SRC_B_IMM, ALU_IR);
            state_d = S_ALUWB;
         end

         S_EXEC_RW: begin
            ctrl    = alu_ctrl(SRC_A_RS1, SRC_B_RS2, ALU_IRW);
            state_d = S_ALUWB;
         end

         S_EXEC_IW: begin
            ctrl    = alu_ctrl(SRC_A_RS1, SRC_B_IMM, ALU_IRW);
            state_d = S_ALUWB;
         end

         S_AUIPC: begin
            ctrl    = alu_ctrl(SRC_A_OLD_PC, SRC_B_IMM, ALU_ADD);
            state_d = S_ALUWB;
         end

         S_ALUWB: begin
            ctrl.result_src   = RES_ALUOUT;
            ctrl.reg_write_en = 1'b1;
            state_d           = S_FETCH;
         end

         S_BRANCH: begin
            ctrl            = alu_ctrl(SRC_A_RS1, SRC_B_RS2, ALU_SUB);
            ctrl.result_src = RES_ALUOUT;
            ctrl.branch     = 1'b1;
            state_d         = S_FETCH;
         end

         // Jump target (computed in DECODE) sits in ALUOUT; ALU forms the link value.
         S_JAL: begin
            ctrl            = alu_ctrl(SRC_A_OLD_PC, SRC_B_FOUR, ALU_ADD);
            ctrl.result_src = RES_ALUOUT;
            ctrl.pc_update  = 1'b1;
            state_d         = S_ALUWB;
         end

         S_JALR: begin
            ctrl            = alu_ctrl(SRC_A_RS1, SRC_B_IMM, ALU_ADD);
            ctrl.result_src = RES_ALU;
            ctrl.pc_update  = 1'b1;
            state_d         = S_JALR_WB;
         end

         S_JALR_WB: begin
            ctrl              = alu_ctrl(SRC_A_OLD_PC, SRC_B_FOUR, ALU_ADD);
            ctrl.result_src   = RES_ALU;
            ctrl.reg_write_en = 1'b1;
            state_d           = S_FETCH;
         end

         S_LUI: begin
            ctrl.result_src   = RES_IMM;
            ctrl.reg_write_en = 1'b1;
            state_d           = S_FETCH;
         end

         default: begin
            ctrl    = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.o_mem_req       = ctrl.mem_req;
   assign bus.o_mem_write_en  = ctrl.mem_write_en;
   assign bus.o_ir_write_en   = ctrl.ir_write_en;
   assign bus.o_pc_update     = ctrl.pc_update;
   assign bus.o_branch        = ctrl.branch;
   assign bus.o_reg_write_en  = ctrl.reg_write_en;
   assign bus.o_alu_op        = ctrl.alu_op;
   assign bus.o_alu_src_a     = ctrl.alu_src_a;
   assign bus.o_alu_src_b     = ctrl.alu_src_b;
   assign bus.o_result_src    = ctrl.result_src;
   assign bus.o_illegal_instr = ctrl.illegal_instr;

endmodule
